// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit: FSM states,
// instruction fields and datapath select codes.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StIrLoad,
        StDecode,
        StRExec,
        StAddiExec,
        StLwAddr,
        StLwWb,
        StSwWr,
        StBrCmp,
        StBrTgt,
        StHalt
    } ctrlState_e;

    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;

    localparam logic [2:0] AluNone = 3'b000;
    localparam logic [2:0] AluAdd  = 3'b001;
    localparam logic [2:0] AluSub  = 3'b010;
    localparam logic [2:0] AluAnd  = 3'b011;
    localparam logic [2:0] AluCmp  = 3'b111;

    localparam logic [1:0] SrbB      = 2'b00;
    localparam logic [1:0] SrbImm    = 2'b01;
    localparam logic [1:0] SrbImmSh2 = 2'b10;
    localparam logic [1:0] SrbFour   = 2'b11;

    localparam logic [2:0] IordPc     = 3'b000;
    localparam logic [2:0] IordAluOut = 3'b001;

    localparam logic [1:0] DstRt = 2'b00;
    localparam logic [1:0] DstRd = 2'b01;

    localparam logic [1:0] ExcNone     = 2'b00;
    localparam logic [1:0] ExcOverflow = 2'b01;
    localparam logic [1:0] ExcIllegal  = 2'b10;

    function automatic logic isRFunct(input logic [5:0] funct);
        return (funct == FnAdd) || (funct == FnSub) || (funct == FnAnd);
    endfunction

    function automatic logic [2:0] rFunctAluOp(input logic [5:0] funct);
        case (funct)
            FnAdd:   return AluAdd;
            FnSub:   return AluSub;
            FnAnd:   return AluAnd;
            default: return AluNone;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Saturating 3-bit wait-state counter; done flags the last cycle of a memory wait.
module mem_wait_counter #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic done
);

    localparam logic [2:0] Last = 3'(MEM_WAIT - 1);

    logic [2:0] countQ, countD;

    always_comb begin
        countD = countQ;
        if (clear) begin
            countD = '0;
        end else if (inc && (countQ != Last)) begin
            countD = countQ + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            countQ <= '0;
        end else begin
            countQ <= countD;
        end
    end

    assign done = (countQ == Last);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS-subset datapath.
// Optional macro OVERFLOW_TRAP_EN: add/sub/addi overflow suppresses the write and halts.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1  // legal range 1..7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPCode,
    input  logic [5:0] Funct,
    input  logic       Of,
    input  logic       Eq,
    output logic       PCWrite,
    output logic       MemControl,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       LoadA,
    output logic       LoadB,
    output logic       ALUSrA,
    output logic       MemToReg,
    output logic [1:0] RegDST,
    output logic [1:0] ALUSrB,
    output logic [1:0] RegReadOne,
    output logic [2:0] IordD,
    output logic [2:0] ALUOp,
    output logic       Halted,
    output logic [1:0] ExcCause
);

    ctrlState_e stateQ, stateD;
    logic [1:0] excQ, excD;
    logic       brEqQ;
    logic       cntDone;
    logic       cntClear;
    logic       cntInc;

`ifndef OVERFLOW_TRAP_EN
    logic unusedOf;
    assign unusedOf = Of;
`endif

    assign cntClear = (stateD != stateQ);
    assign cntInc   = (stateQ == StFetch) || (stateQ == StLwAddr);

    mem_wait_counter #(
        .MEM_WAIT(MEM_WAIT)
    ) uWaitCnt (
        .clk  (clk),
        .reset(reset),
        .clear(cntClear),
        .inc  (cntInc),
        .done (cntDone)
    );

    always_comb begin
        stateD     = stateQ;
        excD       = excQ;
        PCWrite    = 1'b0;
        MemControl = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        LoadA      = 1'b0;
        LoadB      = 1'b0;
        ALUSrA     = 1'b0;
        MemToReg   = 1'b0;
        RegDST     = DstRt;
        ALUSrB     = SrbB;
        RegReadOne = 2'b00;
        IordD      = IordPc;
        ALUOp      = AluNone;
        Halted     = 1'b0;
        ExcCause   = ExcNone;

        unique case (stateQ)
            StFetch: begin
                if (cntDone) stateD = StIrLoad;
            end
            StIrLoad: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrB  = SrbFour;
                ALUOp   = AluAdd;
                stateD  = StDecode;
            end
            StDecode: begin
                LoadA = 1'b1;
                LoadB = 1'b1;
                case (OPCode)
                    OpRType: begin
                        if (isRFunct(Funct)) begin
                            stateD = StRExec;
                        end else begin
                            stateD = StHalt;
                            excD   = ExcIllegal;
                        end
                    end
                    OpAddi:       stateD = StAddiExec;
                    OpLw:         stateD = StLwAddr;
                    OpSw:         stateD = StSwWr;
                    OpBeq, OpBne: stateD = StBrCmp;
                    default: begin
                        stateD = StHalt;
                        excD   = ExcIllegal;
                    end
                endcase
            end
            StRExec: begin
                ALUSrA   = 1'b1;
                ALUOp    = rFunctAluOp(Funct);
                RegDST   = DstRd;
                RegWrite = 1'b1;
                stateD   = StFetch;
`ifdef OVERFLOW_TRAP_EN
                // AND cannot overflow, so its Of flag is meaningless
                if (Of && (Funct != FnAnd)) begin
                    RegWrite = 1'b0;
                    stateD   = StHalt;
                    excD     = ExcOverflow;
                end
`endif
            end
            StAddiExec: begin
                ALUSrA   = 1'b1;
                ALUSrB   = SrbImm;
                ALUOp    = AluAdd;
                RegWrite = 1'b1;
                stateD   = StFetch;
`ifdef OVERFLOW_TRAP_EN
                if (Of) begin
                    RegWrite = 1'b0;
                    stateD   = StHalt;
                    excD     = ExcOverflow;
                end
`endif
            end
            StLwAddr, StLwWb: begin
                ALUSrA = 1'b1;
                ALUSrB = SrbImm;
                ALUOp  = AluAdd;
                IordD  = IordAluOut;
                if (stateQ == StLwWb) begin
                    MemToReg = 1'b1;
                    RegWrite = 1'b1;
                    stateD   = StFetch;
                end else if (cntDone) begin
                    stateD = StLwWb;
                end
            end
            StSwWr: begin
                ALUSrA     = 1'b1;
                ALUSrB     = SrbImm;
                ALUOp      = AluAdd;
                IordD      = IordAluOut;
                MemControl = 1'b1;
                stateD     = StFetch;
            end
            StBrCmp: begin
                ALUSrA = 1'b1;
                ALUOp  = AluCmp;
                stateD = StBrTgt;
            end
            StBrTgt: begin
                ALUSrB  = SrbImmSh2;
                ALUOp   = AluAdd;
                PCWrite = (OPCode == OpBeq) ? brEqQ : !brEqQ;
                stateD  = StFetch;
            end
            StHalt: begin
                Halted   = 1'b1;
                ExcCause = excQ;
            end
            default: stateD = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stateQ <= StFetch;
            excQ   <= ExcNone;
            brEqQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            excQ   <= excD;
            if (stateQ == StBrCmp) brEqQ <= Eq;
        end
    end

endmodule
